// File: rtl/axi_llc_tag_req_gen.sv
// axi_llc_tag_req_gen
//
// Requester-side front end of the LLC tag storage. It turns hit/miss descriptors into tag store
// requests (Lookup, Flush, Bist) and derives the way indicator from the SPM lock and flushed
// vectors. It tracks outstanding requests in order and pairs each tag store response with the
// descriptor that caused it.
//
// Ports:
//   clk_i, rst_i                               clock, synchronous active-high reset
//   spm_lock_i, flushed_i                      ways configured as SPM / already flushed
//   desc_i, desc_valid_i, desc_ready_o         descriptor handshake
//   store_req_o, store_valid_o, store_ready_i  request to the tag store
//   store_res_i, store_valid_i, store_ready_o  response from the tag store
//   out_o, out_valid_o, out_ready_i            descriptor paired with its response
//   bist_start_i                               BIST request, level-sampled in Idle
//   bist_valid_i, bist_res_i                   BIST completion from the tag store
//   bist_busy_o, bist_done_o, bist_res_o       BIST status (done is a one-cycle pulse)

package axi_llc_tag_req_gen_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned IndexWidth;
    int unsigned TagWidth;
  } cfg_t;

  localparam cfg_t Cfg = '{SetAssociativity: 32'd4, IndexWidth: 32'd8, TagWidth: 32'd16};

  localparam int unsigned W = Cfg.SetAssociativity;

  typedef logic [W-1:0]                way_ind_t;
  typedef logic [Cfg.IndexWidth-1:0]   index_t;
  typedef logic [Cfg.TagWidth-1:0]     tag_t;

  typedef enum logic [1:0] {
    Lookup = 2'd0,
    Flush  = 2'd1,
    Bist   = 2'd2
  } tag_mode_e;

  typedef struct packed {
    index_t   index;
    tag_t     tag;
    logic     dirty;
    logic     flush;
    way_ind_t flush_way;
  } desc_t;

  typedef struct packed {
    tag_mode_e mode;
    way_ind_t  indicator;
    index_t    index;
    tag_t      tag;
    logic      dirty;
  } store_req_t;

  typedef struct packed {
    way_ind_t indicator;
    logic     hit;
    logic     evict;
    tag_t     evict_tag;
  } store_res_t;

  typedef struct packed {
    desc_t      desc;
    store_res_t res;
  } out_t;

endpackage

module axi_llc_tag_req_gen
  import axi_llc_tag_req_gen_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  way_ind_t   spm_lock_i,
  input  way_ind_t   flushed_i,
  input  desc_t      desc_i,
  input  logic       desc_valid_i,
  output logic       desc_ready_o,
  output store_req_t store_req_o,
  output logic       store_valid_o,
  input  logic       store_ready_i,
  input  store_res_t store_res_i,
  input  logic       store_valid_i,
  output logic       store_ready_o,
  output out_t       out_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  input  logic       bist_start_i,
  input  logic       bist_valid_i,
  input  way_ind_t   bist_res_i,
  output logic       bist_busy_o,
  output logic       bist_done_o,
  output way_ind_t   bist_res_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StBistReq  = 2'd1,
    StBistWait = 2'd2
  } state_e;

  // Tracking entry: bypass entries never see a tag store response.
  typedef struct packed {
    desc_t desc;
    logic  bypass;
  } fifo_entry_t;

  state_e      r_state;
  logic        r_valid;
  store_req_t  r_req;
  logic        r_bist_done;
  way_ind_t    r_bist_res;

  fifo_entry_t     r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;

  logic        w_idle;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_desc_acc;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  way_ind_t    w_indicator;
  store_req_t  w_desc_req;
  store_req_t  w_bist_req;
  fifo_entry_t w_head;

  assign w_idle       = (r_state == StIdle);
  assign w_fifo_full  = (r_cnt == CntW'(MaxOutstanding));
  assign w_fifo_empty = (r_cnt == '0);

  // The output slot must be free or draining before a new descriptor can load it.
  assign desc_ready_o = !rst_i && w_idle && !bist_start_i && !w_fifo_full &&
                        (!r_valid || store_ready_i);
  assign w_desc_acc   = desc_valid_i && desc_ready_o;

  always_comb begin
    w_indicator = ~spm_lock_i & ~flushed_i;
    if (desc_i.flush) begin
      w_indicator = desc_i.flush_way;
    end
  end

  // A Lookup with no eligible way skips the tag store entirely.
  assign w_bypass = !desc_i.flush && (w_indicator == '0);

  always_comb begin
    w_desc_req           = '0;
    w_desc_req.mode      = Lookup;
    if (desc_i.flush) begin
      w_desc_req.mode = Flush;
    end
    w_desc_req.indicator = w_indicator;
    w_desc_req.index     = desc_i.index;
    w_desc_req.tag       = desc_i.tag;
    w_desc_req.dirty     = desc_i.dirty;
  end

  always_comb begin
    w_bist_req           = '0;
    w_bist_req.mode      = Bist;
    w_bist_req.indicator = '1;
  end

  // Control FSM, shared request slot and BIST status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_valid     <= 1'b0;
      r_req       <= '0;
      r_bist_done <= 1'b0;
      r_bist_res  <= '0;
    end else begin
      r_bist_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_valid && store_ready_i) begin
            r_valid <= 1'b0;
          end
          if (w_desc_acc && !w_bypass) begin
            r_valid <= 1'b1;
            r_req   <= w_desc_req;
          end else if (bist_start_i && w_fifo_empty && !r_valid) begin
            r_valid <= 1'b1;
            r_req   <= w_bist_req;
            r_state <= StBistReq;
          end
        end
        StBistReq: begin
          if (store_ready_i) begin
            r_valid <= 1'b0;
            r_state <= StBistWait;
          end
        end
        StBistWait: begin
          if (bist_valid_i) begin
            r_bist_res  <= bist_res_i;
            r_bist_done <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign store_valid_o = r_valid;
  assign store_req_o   = r_req;
  assign bist_busy_o   = (r_state != StIdle);
  assign bist_done_o   = r_bist_done;
  assign bist_res_o    = r_bist_res;

  // Response pairing: the head entry decides whether a response is consumed.
  assign w_head        = r_fifo[r_rd_ptr];
  assign out_valid_o   = !w_fifo_empty && (w_head.bypass || store_valid_i);
  assign store_ready_o = !w_fifo_empty && !w_head.bypass && out_ready_i;

  always_comb begin
    out_o.desc = w_head.desc;
    out_o.res  = store_res_i;
    if (w_head.bypass) begin
      out_o.res = '0;
    end
  end

  assign w_push = w_desc_acc;
  assign w_pop  = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{desc: desc_i, bypass: w_bypass};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(MaxOutstanding - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_llc_tag_req_gen.sv
module tb_axi_llc_tag_req_gen;
  import axi_llc_tag_req_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  way_ind_t   spm_lock_i;
  way_ind_t   flushed_i;
  desc_t      desc_i;
  logic       desc_valid_i;
  logic       desc_ready_o;
  store_req_t store_req_o;
  logic       store_valid_o;
  logic       store_ready_i;
  store_res_t store_res_i;
  logic       store_valid_i;
  logic       store_ready_o;
  out_t       out_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       bist_start_i;
  logic       bist_valid_i;
  way_ind_t   bist_res_i;
  logic       bist_busy_o;
  logic       bist_done_o;
  way_ind_t   bist_res_o;

  always #5 clk = ~clk;

  axi_llc_tag_req_gen #(
    .MaxOutstanding(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .spm_lock_i   (spm_lock_i),
    .flushed_i    (flushed_i),
    .desc_i       (desc_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .store_req_o  (store_req_o),
    .store_valid_o(store_valid_o),
    .store_ready_i(store_ready_i),
    .store_res_i  (store_res_i),
    .store_valid_i(store_valid_i),
    .store_ready_o(store_ready_o),
    .out_o        (out_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .bist_start_i (bist_start_i),
    .bist_valid_i (bist_valid_i),
    .bist_res_i   (bist_res_i),
    .bist_busy_o  (bist_busy_o),
    .bist_done_o  (bist_done_o),
    .bist_res_o   (bist_res_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_delay = 0;
  int acc_cnt = 0;
  int bist_req_cnt = 0;
  bit resp_taken = 1'b0;

  out_t       exp_out_q [$];
  store_req_t exp_req_q [$];
  store_req_t ts_pend [$];
  int         ts_due [$];
  out_t       last_out;

  // Tag store reference behaviour: response is a fixed function of the request.
  function automatic store_res_t ts_model(input store_req_t r);
    store_res_t s;
    s.indicator = r.indicator & (~r.indicator + way_ind_t'(1));
    s.hit       = r.tag[1];
    s.evict     = ~r.tag[1] & r.dirty;
    s.evict_tag = ~r.tag;
    return s;
  endfunction

  function automatic desc_t mk_desc(input int idx, input int tag, input bit dirty,
                                    input bit flush, input way_ind_t way);
    desc_t d;
    d.index     = index_t'(idx);
    d.tag       = tag_t'(tag);
    d.dirty     = dirty;
    d.flush     = flush;
    d.flush_way = way;
    return d;
  endfunction

  // Scoreboard monitor: observes handshakes mid-cycle, when everything is settled.
  store_req_t m_req;
  out_t       m_out;
  way_ind_t   m_ind;
  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      exp_out_q.delete();
      exp_req_q.delete();
      ts_pend.delete();
      ts_due.delete();
    end else begin
      if (store_valid_o && store_ready_i) begin
        if (store_req_o.mode == Bist) begin
          bist_req_cnt++;
        end else begin
          checks++;
          if (exp_req_q.size() == 0) begin
            errors++;
            $display("FAIL store_req: got %h, required none", store_req_o);
          end else begin
            m_req = exp_req_q.pop_front();
            if (store_req_o !== m_req) begin
              errors++;
              $display("FAIL store_req: got %h, required %h", store_req_o, m_req);
            end
          end
          ts_pend.push_back(store_req_o);
          ts_due.push_back(cyc + resp_delay);
        end
      end
      if (store_valid_i && store_ready_o) resp_taken = 1'b1;
      if (out_valid_o && out_ready_i) begin
        checks++;
        last_out = out_o;
        if (exp_out_q.size() == 0) begin
          errors++;
          $display("FAIL out: got %h, required none", out_o);
        end else begin
          m_out = exp_out_q.pop_front();
          if (out_o !== m_out) begin
            errors++;
            $display("FAIL out: got %h, required %h", out_o, m_out);
          end
        end
      end
      if (desc_valid_i && desc_ready_o) begin
        acc_cnt++;
        m_ind = ~spm_lock_i & ~flushed_i;
        if (desc_i.flush) m_ind = desc_i.flush_way;
        m_req = '0;
        m_req.mode = Lookup;
        if (desc_i.flush) m_req.mode = Flush;
        m_req.indicator = m_ind;
        m_req.index = desc_i.index;
        m_req.tag = desc_i.tag;
        m_req.dirty = desc_i.dirty;
        m_out.desc = desc_i;
        if (!desc_i.flush && m_ind == '0) begin
          m_out.res = '0;
        end else begin
          m_out.res = ts_model(m_req);
          exp_req_q.push_back(m_req);
        end
        exp_out_q.push_back(m_out);
      end
    end
  end

  // Tag store response driver.
  always @(posedge clk) begin
    #1;
    if (rst_i) begin
      store_valid_i = 1'b0;
      resp_taken = 1'b0;
    end else begin
      if (resp_taken) begin
        store_valid_i = 1'b0;
        resp_taken = 1'b0;
        if (ts_pend.size() > 0) begin
          ts_pend.delete(0);
          ts_due.delete(0);
        end
      end
      if (!store_valid_i && ts_pend.size() > 0 && cyc >= ts_due[0]) begin
        store_valid_i = 1'b1;
        store_res_i = ts_model(ts_pend[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_desc(input desc_t d);
    int n = 0;
    desc_i = d;
    desc_valid_i = 1'b1;
    #1;
    while (!desc_ready_o && n < 50) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (!desc_ready_o) begin
      errors++;
      $display("FAIL desc_accept_timeout: ready=%b, required 1", desc_ready_o);
    end
    tick();
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_out_q.size() != 0 || exp_req_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_out_q.size() != 0 || exp_req_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending out=%0d req=%0d, required 0 0",
               exp_out_q.size(), exp_req_q.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({store_valid_o, desc_ready_o, out_valid_o, store_ready_o, bist_busy_o, bist_done_o}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got sv=%b dr=%b ov=%b sr=%b busy=%b done=%b, required all 0",
               store_valid_o, desc_ready_o, out_valid_o, store_ready_o, bist_busy_o,
               bist_done_o);
    end
    checks++;
    if (bist_res_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_bist_res: got %b, required 0000", bist_res_o);
    end
    rst_i = 1'b0;
    tick();
    #1;
    checks++;
    if (desc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", desc_ready_o);
    end
  endtask

  task automatic test_lookup();
    spm_lock_i = 4'b0001;
    flushed_i = 4'b0000;
    resp_delay = 0;
    send_desc(mk_desc(5, 'h12, 1'b0, 1'b0, 4'b0000));
    #1;
    checks++;
    if (store_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL lookup_valid: got %b, required 1", store_valid_o);
    end
    checks++;
    if (store_req_o.indicator !== 4'b1110) begin
      errors++;
      $display("FAIL lookup_indicator: got %b, required 1110", store_req_o.indicator);
    end
    wait_drain();
    checks++;
    if (last_out.desc.index !== 8'd5 || last_out.res.hit !== 1'b1) begin
      errors++;
      $display("FAIL lookup_out: got index=%0d hit=%b, required 5 1",
               last_out.desc.index, last_out.res.hit);
    end
  endtask

  task automatic test_bypass();
    spm_lock_i = 4'b0011;
    flushed_i = 4'b1100;
    send_desc(mk_desc(3, 'h77, 1'b1, 1'b0, 4'b0000));
    #1;
    checks++;
    if (store_valid_o !== 1'b0 || out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ctrl: got sv=%b ov=%b, required 0 1", store_valid_o, out_valid_o);
    end
    checks++;
    if (out_o.res.indicator !== 4'b0000 || out_o.res.evict !== 1'b0) begin
      errors++;
      $display("FAIL bypass_res: got ind=%b evict=%b, required 0000 0",
               out_o.res.indicator, out_o.res.evict);
    end
    wait_drain();
  endtask

  task automatic test_ordering();
    resp_delay = 5;
    spm_lock_i = 4'b0011;
    flushed_i = 4'b1100;
    send_desc(mk_desc(1, 'h33, 1'b1, 1'b1, 4'b0100));
    send_desc(mk_desc(2, 'h44, 1'b0, 1'b0, 4'b0000));
    desc_i = mk_desc(4, 'h55, 1'b0, 1'b1, 4'b1000);
    desc_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (desc_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL ordering_full: cycle %0d got ready=%b ov=%b, required 0 0",
                 i, desc_ready_o, out_valid_o);
      end
      tick();
    end
    send_desc(mk_desc(4, 'h55, 1'b0, 1'b1, 4'b1000));
    wait_drain();
    resp_delay = 0;
  endtask

  task automatic test_backpressure();
    store_req_t exp_a;
    spm_lock_i = 4'b0000;
    flushed_i = 4'b0000;
    store_ready_i = 1'b0;
    exp_a = '0;
    exp_a.mode = Lookup;
    exp_a.indicator = 4'b1111;
    exp_a.index = 8'd7;
    exp_a.tag = 16'h0040;
    exp_a.dirty = 1'b1;
    send_desc(mk_desc(7, 'h40, 1'b1, 1'b0, 4'b0000));
    desc_i = mk_desc(9, 'h81, 1'b0, 1'b0, 4'b0000);
    desc_valid_i = 1'b1;
    spm_lock_i = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (store_valid_o !== 1'b1 || store_req_o !== exp_a || desc_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d got sv=%b req=%h ready=%b, required 1 %h 0",
                 i, store_valid_o, store_req_o, desc_ready_o, exp_a);
      end
      tick();
    end
    store_ready_i = 1'b1;
    #1;
    checks++;
    if (desc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_resume: got %b, required 1", desc_ready_o);
    end
    tick();
    desc_valid_i = 1'b0;
    #1;
    checks++;
    if (store_valid_o !== 1'b1 || store_req_o.indicator !== 4'b0111) begin
      errors++;
      $display("FAIL backpressure_next: got sv=%b ind=%b, required 1 0111",
               store_valid_o, store_req_o.indicator);
    end
    wait_drain();
    spm_lock_i = 4'b0000;
  endtask

  task automatic test_bist();
    int acc0 = acc_cnt;
    int b0 = bist_req_cnt;
    desc_i = mk_desc(6, 'h10, 1'b0, 1'b0, 4'b0000);
    desc_valid_i = 1'b1;
    bist_start_i = 1'b1;
    #1;
    checks++;
    if (desc_ready_o !== 1'b0 || bist_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bist_start: got ready=%b busy=%b, required 0 0", desc_ready_o, bist_busy_o);
    end
    tick();
    #1;
    checks++;
    if (bist_busy_o !== 1'b1 || store_valid_o !== 1'b1 || store_req_o.mode !== Bist ||
        store_req_o.indicator !== 4'b1111 || desc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bist_req: got busy=%b sv=%b mode=%0d ind=%b ready=%b, required 1 1 2 1111 0",
               bist_busy_o, store_valid_o, store_req_o.mode, store_req_o.indicator,
               desc_ready_o);
    end
    bist_start_i = 1'b0;
    tick();
    #1;
    checks++;
    if (store_valid_o !== 1'b0 || bist_busy_o !== 1'b1 || bist_done_o !== 1'b0) begin
      errors++;
      $display("FAIL bist_wait: got sv=%b busy=%b done=%b, required 0 1 0",
               store_valid_o, bist_busy_o, bist_done_o);
    end
    tick();
    tick();
    bist_valid_i = 1'b1;
    bist_res_i = 4'b0010;
    tick();
    bist_valid_i = 1'b0;
    bist_res_i = 4'b1111;
    desc_valid_i = 1'b0;
    #1;
    checks++;
    if (bist_done_o !== 1'b1 || bist_res_o !== 4'b0010 || bist_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bist_done: got done=%b res=%b busy=%b, required 1 0010 0",
               bist_done_o, bist_res_o, bist_busy_o);
    end
    checks++;
    if (acc_cnt !== acc0 || bist_req_cnt !== b0 + 1) begin
      errors++;
      $display("FAIL bist_counts: got accepted=%0d bist_reqs=%0d, required %0d %0d",
               acc_cnt - acc0, bist_req_cnt - b0, 0, 1);
    end
    tick();
    #1;
    checks++;
    if (bist_done_o !== 1'b0 || bist_res_o !== 4'b0010) begin
      errors++;
      $display("FAIL bist_pulse: got done=%b res=%b, required 0 0010", bist_done_o, bist_res_o);
    end
  endtask

  task automatic test_reset_mid();
    resp_delay = 20;
    spm_lock_i = 4'b0000;
    flushed_i = 4'b0000;
    send_desc(mk_desc(11, 'h21, 1'b0, 1'b0, 4'b0000));
    send_desc(mk_desc(12, 'h22, 1'b1, 1'b0, 4'b0000));
    rst_i = 1'b1;
    tick();
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || store_valid_o !== 1'b0 || store_ready_o !== 1'b0 ||
        desc_ready_o !== 1'b0 || bist_res_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: got ov=%b sv=%b sr=%b dr=%b bres=%b, required 0 0 0 0 0000",
               out_valid_o, store_valid_o, store_ready_o, desc_ready_o, bist_res_o);
    end
    rst_i = 1'b0;
    resp_delay = 0;
    tick();
    spm_lock_i = 4'b1111;
    send_desc(mk_desc(13, 'h23, 1'b0, 1'b0, 4'b0000));
    #1;
    checks++;
    if (out_valid_o !== 1'b1 || out_o.desc.index !== 8'd13) begin
      errors++;
      $display("FAIL reset_mid_empty: got ov=%b index=%0d, required 1 13",
               out_valid_o, out_o.desc.index);
    end
    wait_drain();
    spm_lock_i = 4'b0000;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      spm_lock_i = way_ind_t'($urandom_range(0, 15));
      flushed_i = way_ind_t'($urandom_range(0, 15));
      resp_delay = $urandom_range(0, 2);
      send_desc(mk_desc($urandom_range(0, 255), $urandom_range(0, 65535),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        way_ind_t'($urandom_range(0, 15))));
    end
    wait_drain();
    resp_delay = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    spm_lock_i = '0;
    flushed_i = '0;
    desc_i = '0;
    desc_valid_i = 1'b0;
    store_ready_i = 1'b1;
    store_res_i = '0;
    store_valid_i = 1'b0;
    out_ready_i = 1'b1;
    bist_start_i = 1'b0;
    bist_valid_i = 1'b0;
    bist_res_i = '0;
    last_out = '0;
    test_reset();
    test_lookup();
    test_bypass();
    test_ordering();
    test_backpressure();
    test_bist();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
